// File: rtl/free_list.sv
// Circular free list of physical register tags for a 3-wide rename stage, with a
// committed head for one-cycle flush recovery. Optional checker: define FL_CHECK_EN.
module free_list #(
    parameter int N_PREG = 32,
    parameter int N_AREG = 8,
    parameter int PW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          freeze_front,
    input  logic          req_alloc,
    output logic [PW-1:0] Pw_new_x,
    output logic [PW-1:0] Pw_new_y,
    output logic [PW-1:0] Pw_new_z,
    output logic          stall_FL,
    input  logic          RegWr_x,
    input  logic          RegWr_y,
    input  logic          RegWr_z,
    input  logic [PW-1:0] Pw_retire_x,
    input  logic [PW-1:0] Pw_retire_y,
    input  logic [PW-1:0] Pw_retire_z,
    output logic [PW:0]   count_FL
`ifdef FL_CHECK_EN
    ,
    output logic          err_FL
`endif
);
    localparam int N_FREE = N_PREG - N_AREG;

    logic [PW-1:0] slot_q [N_PREG];
    logic [PW-1:0] slot_d [N_PREG];
    logic [PW:0]   head_q, head_d, tail_q, tail_d, cmt_q, cmt_d;
    logic [2:0]    reg_wr;
    logic [1:0]    n_ret;
    logic          alloc_fire;
    logic [PW-1:0] hx, hy, hz, tx, ty, tz;

    always_comb begin
        reg_wr = {RegWr_z, RegWr_y, RegWr_x};
        // Only prefix-contiguous retire patterns are honoured; anything else retires nothing.
        case (reg_wr)
            3'b001:  n_ret = 2'd1;
            3'b011:  n_ret = 2'd2;
            3'b111:  n_ret = 2'd3;
            default: n_ret = 2'd0;
        endcase

        count_FL   = tail_q - head_q;
        stall_FL   = count_FL < (PW+1)'(3);
        alloc_fire = req_alloc & ~freeze_front & ~stall_FL & ~flush;

        hx = head_q[PW-1:0];
        hy = hx + PW'(1);
        hz = hx + PW'(2);
        tx = tail_q[PW-1:0];
        ty = tx + PW'(1);
        tz = tx + PW'(2);

        Pw_new_x = slot_q[hx];
        Pw_new_y = slot_q[hy];
        Pw_new_z = slot_q[hz];

        slot_d = slot_q;
        if (n_ret >= 2'd1) slot_d[tx] = Pw_retire_x;
        if (n_ret >= 2'd2) slot_d[ty] = Pw_retire_y;
        if (n_ret == 2'd3) slot_d[tz] = Pw_retire_z;

        tail_d = tail_q + (PW+1)'(n_ret);
        cmt_d  = cmt_q + (PW+1)'(n_ret);

        // Flush rewinds to the committed head, including whatever retires this cycle.
        if (flush)           head_d = cmt_q + (PW+1)'(n_ret);
        else if (alloc_fire) head_d = head_q + (PW+1)'(3);
        else                 head_d = head_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PREG; i++)
                slot_q[i] <= (i < N_FREE) ? PW'(i + N_AREG) : '0;
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= (PW+1)'(N_FREE);
        end else begin
            slot_q <= slot_d;
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

`ifdef FL_CHECK_EN
    logic [N_PREG-1:0] free_q, free_d;
    logic              err_q, err_d;
    logic              dup;
    logic [PW:0]       cnt_new;
    logic [PW-1:0]     off;

    always_comb begin
        free_d  = free_q;
        dup     = 1'b0;
        cnt_new = tail_d - head_d;
        off     = '0;

        if (n_ret >= 2'd1) dup = dup | free_q[Pw_retire_x];
        if (n_ret >= 2'd2) dup = dup | free_q[Pw_retire_y];
        if (n_ret == 2'd3) dup = dup | free_q[Pw_retire_z];

        if (flush) begin
            free_d = '0;
            for (int i = 0; i < N_PREG; i++) begin
                off = PW'(i) - head_d[PW-1:0];
                if ({1'b0, off} < cnt_new) free_d[slot_d[i]] = 1'b1;
            end
        end else begin
            if (alloc_fire) begin
                free_d[Pw_new_x] = 1'b0;
                free_d[Pw_new_y] = 1'b0;
                free_d[Pw_new_z] = 1'b0;
            end
            if (n_ret >= 2'd1) free_d[Pw_retire_x] = 1'b1;
            if (n_ret >= 2'd2) free_d[Pw_retire_y] = 1'b1;
            if (n_ret == 2'd3) free_d[Pw_retire_z] = 1'b1;
        end

        // A request that reaches the list while it is short of tags means rename ignored stall_FL.
        err_d = err_q | dup
              | ((reg_wr != 3'b000) && (n_ret == 2'd0))
              | (({1'b0, count_FL} + (PW+2)'(n_ret)) > (PW+2)'(N_FREE))
              | (req_alloc & ~freeze_front & ~flush & stall_FL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PREG; i++)
                free_q[i] <= (i >= N_AREG);
            err_q <= 1'b0;
        end else begin
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

    assign err_FL = err_q;
`endif

endmodule
